// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // Iteration counter must reach xlen-1; sized to hold xlen itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder, the multiplier's only arithmetic element.
module ripple_carry_adder #(
  parameter int unsigned xlen = 64
) (
  input  logic [xlen-1:0] a,
  input  logic [xlen-1:0] b,
  input  logic            carry_in,
  output logic [xlen-1:0] sum,
  output logic            carry_out
);

  logic carry;

  always_comb begin
    sum   = '0;
    carry = carry_in;
    for (int unsigned i = 0; i < xlen; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    carry_out = carry;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier with valid/ready on both sides.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned xlen = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [xlen-1:0]   a,
  input  logic [xlen-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*xlen-1:0] product
);

  localparam int unsigned CNT_W = cnt_width(xlen);

  mul_state_t         state, state_nxt;
  logic [2*xlen-1:0]  acc, acc_nxt;
  logic [2*xlen-1:0]  mcand, mcand_nxt;
  logic [2*xlen-1:0]  sum;
  logic [xlen-1:0]    mplier, mplier_nxt;
  logic [CNT_W-1:0]   count, count_nxt;

  ripple_carry_adder #(.xlen(2 * xlen)) u_adder (
    .a        (acc),
    .b        (mcand),
    .carry_in (1'b0),
    .sum      (sum),
    .carry_out()
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= MUL_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      count  <= count_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    count_nxt  = count;
    case (state)
      MUL_IDLE: begin
        if (in_valid) begin
          acc_nxt    = '0;
          mcand_nxt  = {{xlen{1'b0}}, a};
          mplier_nxt = b;
          count_nxt  = '0;
          state_nxt  = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
`ifdef MUL_EARLY_TERM_EN
        if (mplier == '0) begin
          state_nxt = MUL_DONE;
        end else
`endif
        begin
          if (mplier[0]) acc_nxt = sum;
          mcand_nxt  = mcand << 1;
          mplier_nxt = mplier >> 1;
          count_nxt  = count + 1'b1;
          if (count == CNT_W'(xlen - 1)) state_nxt = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (out_ready) state_nxt = MUL_IDLE;
      end
      default: state_nxt = MUL_IDLE;
    endcase
  end

  assign in_ready  = (state == MUL_IDLE);
  assign out_valid = (state == MUL_DONE);
  assign product   = acc;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: xlen=64 and xlen=8 instances against a latency/product model.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [1:0]  in_valid_v, out_ready_v, in_ready_w, out_valid_w;
  logic [63:0] a_v [2];
  logic [63:0] b_v [2];
  logic [127:0] p64;
  logic [15:0]  p8;

  int n_cmp = 0;
  int n_err = 0;

  shift_add_multiplier #(.xlen(64)) dut64 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
    .a(a_v[0]), .b(b_v[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_v[0]),
    .product(p64)
  );

  shift_add_multiplier #(.xlen(8)) dut8 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_v[1]),
    .product(p8)
  );

  function automatic int xl_of(input int i);
    return (i == 0) ? 64 : 8;
  endfunction

  function automatic logic [127:0] prod_of(input int i);
    return (i == 0) ? p64 : {112'b0, p8};
  endfunction

  function automatic logic [63:0] mask_of(input int xl);
    logic [63:0] m;
    m = (xl >= 64) ? '1 : ((64'd1 << xl) - 64'd1);
    return m;
  endfunction

  // Cycles from accept edge to out_valid, derived from the operand value.
  function automatic int lat_of(input logic [63:0] bv, input int xl);
`ifdef MUL_EARLY_TERM_EN
    int k;
    if (bv == 0) return 1;
    k = 0;
    for (int j = 0; j < 64; j++) if (bv[j]) k = j;
    return (k + 2 < xl) ? k + 2 : xl;
`else
    return xl + 0 * int'(bv[0]);
`endif
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: phase 0 idle, 1 busy (countdown), 2 done.
  int           m_phase [2];
  int           m_left  [2];
  logic [127:0] m_prod  [2];
  logic [63:0]  am, bm;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = 0;
        m_left[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (m_phase[i])
          0: if (in_valid_v[i]) begin
               am = a_v[i] & mask_of(xl_of(i));
               bm = b_v[i] & mask_of(xl_of(i));
               m_prod[i]  = {64'b0, am} * {64'b0, bm};
               m_left[i]  = lat_of(bm, xl_of(i));
               m_phase[i] = 1;
             end
          1: begin
               m_left[i]--;
               if (m_left[i] == 0) m_phase[i] = 2;
             end
          default: if (out_ready_v[i]) m_phase[i] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("in_ready[%0d]", i), {127'b0, in_ready_w[i]}, {127'b0, m_phase[i] == 0});
        chk($sformatf("out_valid[%0d]", i), {127'b0, out_valid_w[i]}, {127'b0, m_phase[i] == 2});
        if (m_phase[i] == 2) chk($sformatf("product[%0d]", i), prod_of(i), m_prod[i]);
      end
    end
  end

  // All tasks start and end on a falling edge.
  task automatic start_op(input int i, input logic [63:0] av, input logic [63:0] bv);
    int n;
    n = 0;
    while (!in_ready_w[i] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("in_ready_timeout", 128'd0, 128'd1);
    a_v[i] = av;
    b_v[i] = bv;
    in_valid_v[i] = 1'b1;
    out_ready_v[i] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input bit noise, output int lat);
    lat = 0;
    while (lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (noise) begin
        in_valid_v[i] = 1'($urandom);
        a_v[i] = {$urandom, $urandom};
        b_v[i] = {$urandom, $urandom};
      end
      if (out_valid_w[i]) break;
    end
    if (!out_valid_w[i]) chk("out_valid_timeout", 128'd0, 128'd1);
  endtask

  task automatic handoff(input int i);
    in_valid_v[i] = 1'b0;
    out_ready_v[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_v[i] = 1'b0;
  endtask

  task automatic directed(input int i, input logic [63:0] av, input logic [63:0] bv,
                          input logic [127:0] exp_p, input int exp_lat, input string nm);
    int lat;
    start_op(i, av, bv);
    wait_done(i, 1'b0, lat);
    chk({nm, "_product"}, prod_of(i), exp_p);
    chk({nm, "_latency"}, 128'(lat), 128'(exp_lat));
    handoff(i);
  endtask

  initial begin
    int lat;
    logic [63:0] ra, rb;
    int stall;
    rstn = 1'b0;
    in_valid_v = '0;
    out_ready_v = '0;
    for (int i = 0; i < 2; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {127'b0, in_ready_w[0]}, 128'd1);
    chk("rst_out_valid", {127'b0, out_valid_w[0]}, 128'd0);
    chk("rst_product", p64, 128'd0);
    chk("rst_product8", {112'b0, p8}, 128'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Reset while busy: 5*3 has already accumulated 15 by now.
    start_op(0, 64'd5, 64'd3);
    repeat (9) @(negedge clk);
    chk("busy_product_before_rst", p64, 128'd15);
    rstn = 1'b0;
    #1;
    chk("midrst_product", p64, 128'd0);
    chk("midrst_in_ready", {127'b0, in_ready_w[0]}, 128'd1);
    chk("midrst_out_valid", {127'b0, out_valid_w[0]}, 128'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

`ifdef MUL_EARLY_TERM_EN
    directed(0, 64'd7, 64'd6, 128'd42, 4, "mul7x6");
    directed(0, 64'd12345, 64'd0, 128'd0, 1, "b_zero");
    directed(1, 64'd13, 64'd11, 128'd143, 5, "x8_13x11");
`else
    directed(0, 64'd7, 64'd6, 128'd42, 64, "mul7x6");
    directed(0, 64'd12345, 64'd0, 128'd0, 64, "b_zero");
    directed(1, 64'd13, 64'd11, 128'd143, 8, "x8_13x11");
`endif
    directed(0, '1, '1, 128'hFFFFFFFFFFFFFFFE_0000000000000001, 64, "all_ones");
    directed(0, 64'd0, 64'd99, 128'd0, lat_of(64'd99, 64), "a_zero");
    directed(1, 64'd255, 64'd255, 128'hFE01, 8, "x8_all_ones");

    // Backpressure with a competing request held in DONE.
    start_op(0, 64'd3, 64'd5);
    wait_done(0, 1'b0, lat);
    a_v[0] = 64'd9;
    b_v[0] = 64'd9;
    in_valid_v[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("bp_product", p64, 128'd15);
    chk("bp_out_valid", {127'b0, out_valid_w[0]}, 128'd1);
    chk("bp_in_ready", {127'b0, in_ready_w[0]}, 128'd0);
    handoff(0);
    chk("bp_idle_after", {127'b0, in_ready_w[0]}, 128'd1);
    directed(0, 64'd9, 64'd9, 128'd81, lat_of(64'd9, 64), "bp_second");

    for (int r = 0; r < 1150; r++) begin
      int i;
      i = (r < 1000) ? 1 : 0;
      ra = {$urandom, $urandom} & mask_of(xl_of(i));
      rb = {$urandom, $urandom} & mask_of(xl_of(i));
      case ($urandom_range(0, 7))
        0: ra = '0;
        1: rb = '0;
        2: rb = mask_of(xl_of(i));
        3: rb = rb >> $urandom_range(0, xl_of(i) - 1);
        default: ;
      endcase
      start_op(i, ra, rb);
      wait_done(i, 1'b1, lat);
      chk("rand_product", prod_of(i), {64'b0, ra} * {64'b0, rb});
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      handoff(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
